// File: rtl/alarm_clock_pkg.sv
// Shared types, limits and BCD helpers for the time-of-day counter.
package alarm_clock_pkg;

   typedef logic [7:0] bcd2_t;

   localparam bcd2_t HH_MAX = 8'h23;
   localparam bcd2_t MS_MAX = 8'h59;

   typedef enum logic {
      HOLD = 1'b0,
      RUN  = 1'b1
   } tod_state_t;

   // Digit-level check first, so the plain magnitude compare below is valid BCD ordering.
   function automatic logic bcd_valid(input bcd2_t v, input bcd2_t max);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
   endfunction

   function automatic bcd2_t bcd_inc(input bcd2_t v, input bcd2_t max);
      if (v == max) begin
         return 8'h00;
      end
      if (v[3:0] == 4'd9) begin
         return {v[7:4] + 4'd1, 4'd0};
      end
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

endpackage

// File: rtl/tick_edge_sync.sv
// Synchronizes the async 1 Hz tick into clk and emits a registered 1-cycle pulse per rising edge.
module tick_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic tick_in,
   output logic tick_evt
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   // History resets low so a tick already high at reset release is seen as one rise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q   <= '0;
         hist_q   <= 1'b0;
         tick_evt <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], tick_in};
         hist_q   <= sync_q[SYNC_STAGES-1];
         tick_evt <= sync_q[SYNC_STAGES-1] & ~hist_q;
      end
   end

endmodule

// File: rtl/time_of_day_counter.sv
// 24-hour BCD HH:MM:SS counter driven by a synchronized 1 Hz tick, with time-set loads.
// Optional alarm compare enabled by defining ALARM_MATCH_EN.
//
//  state | meaning
//  HOLD  | time frozen, tick events discarded
//  RUN   | each tick event advances time by one second
module time_of_day_counter
   import alarm_clock_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_in,
   input  logic       run_en,
   input  logic       load_valid,
   output logic       load_ready,
   input  logic [7:0] load_hh,
   input  logic [7:0] load_mm,
   input  logic [7:0] load_ss,
   output logic       load_err,
   output logic [7:0] hh_bcd,
   output logic [7:0] mm_bcd,
   output logic [7:0] ss_bcd,
   output logic       sec_pulse,
`ifdef ALARM_MATCH_EN
   input  logic [7:0] alarm_hh,
   input  logic [7:0] alarm_mm,
   input  logic       alarm_arm,
   output logic       alarm_hit,
`endif
   output logic       day_wrap
);

   tod_state_t state, state_nxt;
   logic       tick_evt;
   logic       load_xfer;
   logic       load_ok;
   logic       inc_go;
   logic       wrap;
   bcd2_t      hh_nxt, mm_nxt, ss_nxt;

   tick_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_tick_sync (
      .clk      (clk),
      .reset    (reset),
      .tick_in  (tick_in),
      .tick_evt (tick_evt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= HOLD;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         HOLD: if (run_en)  state_nxt = RUN;
         RUN:  if (!run_en) state_nxt = HOLD;
      endcase
   end

   // Ready drops only while a committed increment is being presented.
   assign load_ready = ~sec_pulse;
   assign load_xfer  = load_valid & load_ready;
   assign load_ok    = bcd_valid(load_hh, HH_MAX) && bcd_valid(load_mm, MS_MAX) &&
                       bcd_valid(load_ss, MS_MAX);
   assign inc_go     = tick_evt && (state == RUN) && !load_xfer;

   always_comb begin
      ss_nxt = bcd_inc(ss_bcd, MS_MAX);
      mm_nxt = mm_bcd;
      hh_nxt = hh_bcd;
      wrap   = 1'b0;
      if (ss_bcd == MS_MAX) begin
         mm_nxt = bcd_inc(mm_bcd, MS_MAX);
         if (mm_bcd == MS_MAX) begin
            hh_nxt = bcd_inc(hh_bcd, HH_MAX);
            wrap   = (hh_bcd == HH_MAX);
         end
      end
   end

`ifdef ALARM_MATCH_EN
   logic alarm_match;
   assign alarm_match = alarm_arm && ({hh_nxt, mm_nxt, ss_nxt} == {alarm_hh, alarm_mm, 8'h00});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alarm_hit <= 1'b0;
      end else begin
         alarm_hit <= inc_go & alarm_match;
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hh_bcd    <= 8'h00;
         mm_bcd    <= 8'h00;
         ss_bcd    <= 8'h00;
         sec_pulse <= 1'b0;
         day_wrap  <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         sec_pulse <= 1'b0;
         day_wrap  <= 1'b0;
         load_err  <= 1'b0;
         if (load_xfer) begin
            if (load_ok) begin
               hh_bcd <= load_hh;
               mm_bcd <= load_mm;
               ss_bcd <= load_ss;
            end else begin
               load_err <= 1'b1;
            end
         end else if (inc_go) begin
            hh_bcd    <= hh_nxt;
            mm_bcd    <= mm_nxt;
            ss_bcd    <= ss_nxt;
            sec_pulse <= 1'b1;
            day_wrap  <= wrap;
         end
      end
   end

endmodule
